// File: rtl/ariane_periph_axil_arbiter_pkg.sv
// rtl/ariane_periph_axil_arbiter_pkg.sv - shared types and constants for the 2:1 AXI4-Lite arbiter
// Contents: state_e (FSM encoding), op_e (granted operation), STRB_WIDTH for the default 64-bit bus.
package ariane_periph_arb_pkg;

    localparam int DEFAULT_DATA_WIDTH = 64;
    localparam int STRB_WIDTH         = DEFAULT_DATA_WIDTH / 8;

    typedef logic [2:0] state_e;
    localparam state_e IDLE    = 3'd0;
    localparam state_e WR_ADDR = 3'd1;
    localparam state_e WR_RESP = 3'd2;
    localparam state_e RD_ADDR = 3'd3;
    localparam state_e RD_RESP = 3'd4;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

endpackage

// File: rtl/ariane_periph_axil_arbiter_if.sv
// rtl/ariane_periph_axil_arbiter_if.sv - AXI4-Lite bundle with requester (master) and responder (slave) views
// Signals: aw{valid,ready,addr,prot}, w{valid,ready,data,strb}, b{valid,ready,resp},
//          ar{valid,ready,addr,prot}, r{valid,ready,data,resp}.
interface ariane_periph_axil_arbiter_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic                    awvalid;
    logic                    awready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    wvalid;
    logic                    wready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    bvalid;
    logic                    bready;
    logic [1:0]              bresp;
    logic                    arvalid;
    logic                    arready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    rvalid;
    logic                    rready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/ariane_periph_axil_arbiter_rr_arb2.sv
// rtl/ariane_periph_axil_arbiter_rr_arb2.sv - two-requester round-robin picker (combinational)
// Ports: req[1:0] requests, ptr = favoured requester, gnt[1:0] one-hot grant (0 when no request).
module ariane_rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);
    always_comb begin
        gnt = 2'b00;
        if (ptr) begin
            if (req[1])      gnt = 2'b10;
            else if (req[0]) gnt = 2'b01;
        end else begin
            if (req[0])      gnt = 2'b01;
            else if (req[1]) gnt = 2'b10;
        end
    end
endmodule

// File: rtl/ariane_periph_axil_arbiter.sv
// rtl/ariane_periph_axil_arbiter.sv - 2:1 AXI4-Lite arbiter, one transaction in flight
// Ports: aclk, aresetn (async active-low); s0 = core, s1 = debug/host (slave views);
//        m = toward the peripheral register port (master view); grant_o = one-hot owner, 0 when idle.
module ariane_periph_axil_arbiter
    import ariane_periph_arb_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 64
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    ariane_periph_axil_arbiter_if.slave     s0,
    ariane_periph_axil_arbiter_if.slave     s1,
    ariane_periph_axil_arbiter_if.master    m,
    output logic [1:0]                      grant_o
);
    state_e state;
    logic   winner;
    logic   rr_ptr;
    op_e    op_pref;
    logic   aw_done;
    logic   w_done;

    logic [1:0] wr_req;
    logic [1:0] rd_req;
    logic [1:0] gnt;
    logic       sel_wr;
    logic       sel_rd;
    op_e        next_op;

    assign wr_req = {s1.awvalid, s0.awvalid};
    assign rd_req = {s1.arvalid, s0.arvalid};

    ariane_rr_arb2 u_rr (
        .req (wr_req | rd_req),
        .ptr (rr_ptr),
        .gnt (gnt)
    );

    // Operation for the candidate winner; op_pref breaks the tie when it wants both.
    assign sel_wr = |(gnt & wr_req);
    assign sel_rd = |(gnt & rd_req);
    always_comb begin
        if (sel_wr && sel_rd) next_op = op_pref;
        else if (sel_wr)      next_op = OP_WR;
        else                  next_op = OP_RD;
    end

    // Payloads follow the registered winner; only valids/readys are state-gated.
    logic [AXI_ADDR_WIDTH-1:0]   sel_awaddr;
    logic [AXI_ADDR_WIDTH-1:0]   sel_araddr;
    logic [AXI_DATA_WIDTH-1:0]   sel_wdata;
    logic [AXI_DATA_WIDTH/8-1:0] sel_wstrb;

    assign sel_awaddr = winner ? s1.awaddr : s0.awaddr;
    assign sel_araddr = winner ? s1.araddr : s0.araddr;
    assign sel_wdata  = winner ? s1.wdata  : s0.wdata;
    assign sel_wstrb  = winner ? s1.wstrb  : s0.wstrb;

    assign m.awaddr = sel_awaddr;
    assign m.awprot = winner ? s1.awprot : s0.awprot;
    assign m.wdata  = sel_wdata;
    assign m.wstrb  = sel_wstrb;
    assign m.araddr = sel_araddr;
    assign m.arprot = winner ? s1.arprot : s0.arprot;

    // Responses pass through unmodified; ownership is expressed by bvalid/rvalid only.
    assign s0.bresp = m.bresp;
    assign s1.bresp = m.bresp;
    assign s0.rdata = m.rdata;
    assign s1.rdata = m.rdata;
    assign s0.rresp = m.rresp;
    assign s1.rresp = m.rresp;

    always_comb begin
        m.awvalid  = 1'b0;
        m.wvalid   = 1'b0;
        m.bready   = 1'b0;
        m.arvalid  = 1'b0;
        m.rready   = 1'b0;
        s0.awready = 1'b0;
        s0.wready  = 1'b0;
        s0.bvalid  = 1'b0;
        s0.arready = 1'b0;
        s0.rvalid  = 1'b0;
        s1.awready = 1'b0;
        s1.wready  = 1'b0;
        s1.bvalid  = 1'b0;
        s1.arready = 1'b0;
        s1.rvalid  = 1'b0;
        case (state)
            WR_ADDR: begin
                // A channel already handshaken is masked so exactly one beat goes out.
                m.awvalid = (winner ? s1.awvalid : s0.awvalid) & ~aw_done;
                m.wvalid  = (winner ? s1.wvalid  : s0.wvalid)  & ~w_done;
                if (winner) begin
                    s1.awready = m.awready & ~aw_done;
                    s1.wready  = m.wready  & ~w_done;
                end else begin
                    s0.awready = m.awready & ~aw_done;
                    s0.wready  = m.wready  & ~w_done;
                end
            end
            WR_RESP: begin
                m.bready = winner ? s1.bready : s0.bready;
                if (winner) s1.bvalid = m.bvalid;
                else        s0.bvalid = m.bvalid;
            end
            RD_ADDR: begin
                m.arvalid = winner ? s1.arvalid : s0.arvalid;
                if (winner) s1.arready = m.arready;
                else        s0.arready = m.arready;
            end
            RD_RESP: begin
                m.rready = winner ? s1.rready : s0.rready;
                if (winner) s1.rvalid = m.rvalid;
                else        s0.rvalid = m.rvalid;
            end
            default: ;
        endcase
    end

    logic aw_fin;
    logic w_fin;
    assign aw_fin = aw_done | (m.awvalid & m.awready);
    assign w_fin  = w_done  | (m.wvalid  & m.wready);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state   <= IDLE;
            winner  <= 1'b0;
            rr_ptr  <= 1'b0;
            op_pref <= OP_WR;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|gnt) begin
                        winner <= gnt[1];
                        state  <= (next_op == OP_WR) ? WR_ADDR : RD_ADDR;
                    end
                end
                WR_ADDR: begin
                    aw_done <= aw_fin;
                    w_done  <= w_fin;
                    if (aw_fin && w_fin) state <= WR_RESP;
                end
                WR_RESP: begin
                    if (m.bvalid && m.bready) begin
                        state   <= IDLE;
                        rr_ptr  <= ~winner;
                        op_pref <= OP_RD;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end
                end
                RD_ADDR: begin
                    if (m.arvalid && m.arready) state <= RD_RESP;
                end
                RD_RESP: begin
                    if (m.rvalid && m.rready) begin
                        state   <= IDLE;
                        rr_ptr  <= ~winner;
                        op_pref <= OP_WR;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign grant_o = (state == IDLE) ? 2'b00 : (winner ? 2'b10 : 2'b01);

endmodule

// File: tb/tb_ariane_periph_axil_arbiter.sv
// tb/tb_ariane_periph_axil_arbiter.sv - directed vector bench for ariane_periph_axil_arbiter
module tb_ariane_periph_axil_arbiter;

    localparam logic [63:0] A0_AW = 64'h0000_0000_0C00_0004;
    localparam logic [63:0] A1_AW = 64'h0000_0000_0200_0008;
    localparam logic [63:0] A0_AR = 64'h0000_0000_0C00_0010;
    localparam logic [63:0] A1_AR = 64'h0000_0000_0200_BFF8;
    localparam logic [63:0] D0_W  = 64'h0000_0000_0000_0001;
    localparam logic [63:0] D1_W  = 64'h0000_0000_0000_00AA;
    localparam logic [63:0] RDATA = 64'h1234_5678_9ABC_DEF0;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic [1:0] grant;

    ariane_periph_axil_arbiter_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) s0_if ();
    ariane_periph_axil_arbiter_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) s1_if ();
    ariane_periph_axil_arbiter_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) m_if ();

    ariane_periph_axil_arbiter #(.AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s0      (s0_if),
        .s1      (s1_if),
        .m       (m_if),
        .grant_o (grant)
    );

    always #5 aclk = ~aclk;

    // s_in  = {awvalid, wvalid, arvalid, bready, rready}
    // m_in  = {awready, wready, arready, bvalid, rvalid}
    // em    = {m awvalid, wvalid, arvalid, bready, rready}
    // es    = {awready, wready, arready, bvalid, rvalid}
    typedef struct {
        logic       rst;
        logic [4:0] s0_in;
        logic [4:0] s1_in;
        logic [4:0] m_in;
        logic [1:0] bresp;
        logic [1:0] grant;
        logic [4:0] em;
        logic [4:0] es0;
        logic [4:0] es1;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    int wbeats = 0;

    function automatic vec_t mk(input logic rst, input logic [4:0] s0_in, input logic [4:0] s1_in,
                                input logic [4:0] m_in, input logic [1:0] bresp, input logic [1:0] g,
                                input logic [4:0] em, input logic [4:0] es0, input logic [4:0] es1);
        vec_t v;
        v.rst = rst; v.s0_in = s0_in; v.s1_in = s1_in; v.m_in = m_in; v.bresp = bresp;
        v.grant = g; v.em = em; v.es0 = es0; v.es1 = es1;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        @(negedge aclk);
        aresetn = ~v.rst;
        {s0_if.awvalid, s0_if.wvalid, s0_if.arvalid, s0_if.bready, s0_if.rready} = v.s0_in;
        {s1_if.awvalid, s1_if.wvalid, s1_if.arvalid, s1_if.bready, s1_if.rready} = v.s1_in;
        {m_if.awready, m_if.wready, m_if.arready, m_if.bvalid, m_if.rvalid} = v.m_in;
        m_if.bresp = v.bresp;
        #1;
        if (m_if.wvalid && m_if.wready) wbeats++;
        check({tag, " grant"}, grant, v.grant);
        check({tag, " m"}, {m_if.awvalid, m_if.wvalid, m_if.arvalid, m_if.bready, m_if.rready}, v.em);
        check({tag, " s0"}, {s0_if.awready, s0_if.wready, s0_if.arready, s0_if.bvalid, s0_if.rvalid}, v.es0);
        check({tag, " s1"}, {s1_if.awready, s1_if.wready, s1_if.arready, s1_if.bvalid, s1_if.rvalid}, v.es1);
        if (v.em[4]) check({tag, " awaddr"}, m_if.awaddr, (v.grant == 2'b10) ? A1_AW : A0_AW);
        if (v.em[3]) check({tag, " wdata"}, m_if.wdata, (v.grant == 2'b10) ? D1_W : D0_W);
        if (v.em[2]) check({tag, " araddr"}, m_if.araddr, (v.grant == 2'b10) ? A1_AR : A0_AR);
        if (v.es0[1]) check({tag, " s0 bresp"}, s0_if.bresp, v.bresp);
        if (v.es1[1]) check({tag, " s1 bresp"}, s1_if.bresp, v.bresp);
        if (v.es0[0]) check({tag, " s0 rdata"}, s0_if.rdata, RDATA);
        if (v.es1[0]) check({tag, " s1 rdata"}, s1_if.rdata, RDATA);
    endtask

    vec_t tbl[$];

    initial begin
        s0_if.awaddr = A0_AW; s0_if.araddr = A0_AR; s0_if.wdata = D0_W; s0_if.wstrb = 8'h0F;
        s1_if.awaddr = A1_AW; s1_if.araddr = A1_AR; s1_if.wdata = D1_W; s1_if.wstrb = 8'hFF;
        s0_if.awprot = 3'd0; s0_if.arprot = 3'd0; s1_if.awprot = 3'd2; s1_if.arprot = 3'd2;
        {s0_if.awvalid, s0_if.wvalid, s0_if.arvalid, s0_if.bready, s0_if.rready} = 5'b0;
        {s1_if.awvalid, s1_if.wvalid, s1_if.arvalid, s1_if.bready, s1_if.rready} = 5'b0;
        {m_if.awready, m_if.wready, m_if.arready, m_if.bvalid, m_if.rvalid} = 5'b0;
        m_if.bresp = 2'b00; m_if.rresp = 2'b00; m_if.rdata = RDATA;

        // s0 single write, slave ready at once
        tbl.push_back(mk(1, 5'b00000, 5'b00000, 5'b00000, 2'b00, 2'b00, 5'b00000, 5'b00000, 5'b00000));
        tbl.push_back(mk(0, 5'b11010, 5'b00000, 5'b11000, 2'b00, 2'b00, 5'b00000, 5'b00000, 5'b00000));
        tbl.push_back(mk(0, 5'b11010, 5'b00000, 5'b11000, 2'b00, 2'b01, 5'b11000, 5'b11000, 5'b00000));
        tbl.push_back(mk(0, 5'b00010, 5'b00000, 5'b11000, 2'b00, 2'b01, 5'b00010, 5'b00000, 5'b00000));
        tbl.push_back(mk(0, 5'b00010, 5'b00000, 5'b11010, 2'b00, 2'b01, 5'b00010, 5'b00010, 5'b00000));
        tbl.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 2'b00, 2'b00, 5'b00000, 5'b00000, 5'b00000));
        // both masters read from reset: s0 first, then s1
        tbl.push_back(mk(1, 5'b00101, 5'b00101, 5'b00100, 2'b00, 2'b00, 5'b00000, 5'b00000, 5'b00000));
        tbl.push_back(mk(0, 5'b00101, 5'b00101, 5'b00100, 2'b00, 2'b00, 5'b00000, 5'b00000, 5'b00000));
        tbl.push_back(mk(0, 5'b00101, 5'b00101, 5'b00100, 2'b00, 2'b01, 5'b00100, 5'b00100, 5'b00000));
        tbl.push_back(mk(0, 5'b00001, 5'b00101, 5'b00001, 2'b00, 2'b01, 5'b00001, 5'b00001, 5'b00000));
        tbl.push_back(mk(0, 5'b00001, 5'b00101, 5'b00100, 2'b00, 2'b00, 5'b00000, 5'b00000, 5'b00000));
        tbl.push_back(mk(0, 5'b00001, 5'b00101, 5'b00100, 2'b00, 2'b10, 5'b00100, 5'b00000, 5'b00100));
        tbl.push_back(mk(0, 5'b00001, 5'b00001, 5'b00001, 2'b00, 2'b10, 5'b00001, 5'b00000, 5'b00001));
        tbl.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 2'b00, 2'b00, 5'b00000, 5'b00000, 5'b00000));
        // s0 holds aw+ar: WR, RD, WR
        tbl.push_back(mk(0, 5'b11111, 5'b00000, 5'b11111, 2'b00, 2'b00, 5'b00000, 5'b00000, 5'b00000));
        tbl.push_back(mk(0, 5'b11111, 5'b00000, 5'b11111, 2'b00, 2'b01, 5'b11000, 5'b11000, 5'b00000));
        tbl.push_back(mk(0, 5'b11111, 5'b00000, 5'b11111, 2'b00, 2'b01, 5'b00010, 5'b00010, 5'b00000));
        tbl.push_back(mk(0, 5'b11111, 5'b00000, 5'b11111, 2'b00, 2'b00, 5'b00000, 5'b00000, 5'b00000));
        tbl.push_back(mk(0, 5'b11111, 5'b00000, 5'b11111, 2'b00, 2'b01, 5'b00100, 5'b00100, 5'b00000));
        tbl.push_back(mk(0, 5'b11111, 5'b00000, 5'b11111, 2'b00, 2'b01, 5'b00001, 5'b00001, 5'b00000));
        tbl.push_back(mk(0, 5'b11111, 5'b00000, 5'b11111, 2'b01, 2'b00, 5'b00000, 5'b00000, 5'b00000));
        tbl.push_back(mk(0, 5'b11111, 5'b00000, 5'b11111, 2'b01, 2'b01, 5'b11000, 5'b11000, 5'b00000));
        tbl.push_back(mk(0, 5'b11111, 5'b00000, 5'b11111, 2'b01, 2'b01, 5'b00010, 5'b00010, 5'b00000));
        tbl.push_back(mk(0, 5'b00000, 5'b00000, 5'b11111, 2'b01, 2'b00, 5'b00000, 5'b00000, 5'b00000));

        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // W three cycles ahead of AW, AW delayed by slave, B delayed 5 cycles with SLVERR
        wbeats = 0;
        for (int i = 0; i < 3; i++)
            run_vec(mk(0, 5'b01011, 5'b00000, 5'b11000, 2'b00, 2'b00, 5'b00000, 5'b00000, 5'b00000), $sformatf("early_w%0d", i));
        run_vec(mk(0, 5'b11011, 5'b00000, 5'b11000, 2'b00, 2'b00, 5'b00000, 5'b00000, 5'b00000), "wr_req");
        run_vec(mk(0, 5'b11011, 5'b00000, 5'b01000, 2'b00, 2'b01, 5'b11000, 5'b01000, 5'b00000), "w_first");
        run_vec(mk(0, 5'b11011, 5'b00000, 5'b11000, 2'b00, 2'b01, 5'b10000, 5'b10000, 5'b00000), "aw_late");
        for (int i = 0; i < 5; i++)
            run_vec(mk(0, 5'b00011, 5'b10011, 5'b11000, 2'b00, 2'b01, 5'b00010, 5'b00000, 5'b00000), $sformatf("b_wait%0d", i));
        run_vec(mk(0, 5'b00011, 5'b10011, 5'b11010, 2'b10, 2'b01, 5'b00010, 5'b00010, 5'b00000), "b_slverr");
        check("w_beats", wbeats, 1);

        // reset while RD_RESP holds m_rvalid; op_pref and rr_ptr must return to reset values
        run_vec(mk(0, 5'b00100, 5'b00000, 5'b00100, 2'b00, 2'b00, 5'b00000, 5'b00000, 5'b00000), "rst_u1");
        run_vec(mk(0, 5'b00100, 5'b00000, 5'b00100, 2'b00, 2'b01, 5'b00100, 5'b00100, 5'b00000), "rst_u2");
        run_vec(mk(0, 5'b00000, 5'b00000, 5'b00001, 2'b00, 2'b01, 5'b00000, 5'b00001, 5'b00000), "rst_u3");
        run_vec(mk(1, 5'b00000, 5'b00000, 5'b00001, 2'b00, 2'b00, 5'b00000, 5'b00000, 5'b00000), "rst_u4");
        run_vec(mk(1, 5'b11111, 5'b11011, 5'b11111, 2'b00, 2'b00, 5'b00000, 5'b00000, 5'b00000), "rst_u5");
        run_vec(mk(0, 5'b11111, 5'b11011, 5'b11111, 2'b00, 2'b00, 5'b00000, 5'b00000, 5'b00000), "rst_u6");
        run_vec(mk(0, 5'b11111, 5'b11011, 5'b11111, 2'b00, 2'b01, 5'b11000, 5'b11000, 5'b00000), "rst_u7");
        run_vec(mk(0, 5'b11111, 5'b11011, 5'b11111, 2'b00, 2'b01, 5'b00010, 5'b00010, 5'b00000), "rst_u8");
        run_vec(mk(0, 5'b11111, 5'b11011, 5'b11111, 2'b00, 2'b00, 5'b00000, 5'b00000, 5'b00000), "rst_u9");
        run_vec(mk(0, 5'b11111, 5'b11011, 5'b11111, 2'b00, 2'b10, 5'b11000, 5'b00000, 5'b11000), "rst_u10");
        run_vec(mk(0, 5'b11111, 5'b11011, 5'b11111, 2'b00, 2'b10, 5'b00010, 5'b00000, 5'b00010), "rst_u11");
        run_vec(mk(0, 5'b00000, 5'b00000, 5'b00000, 2'b00, 2'b00, 5'b00000, 5'b00000, 5'b00000), "rst_u12");

        // s1 write with AW before W
        run_vec(mk(0, 5'b00000, 5'b10011, 5'b11000, 2'b00, 2'b00, 5'b00000, 5'b00000, 5'b00000), "aw_first1");
        run_vec(mk(0, 5'b00000, 5'b10011, 5'b11000, 2'b00, 2'b10, 5'b10000, 5'b00000, 5'b11000), "aw_first2");
        run_vec(mk(0, 5'b00000, 5'b01011, 5'b11000, 2'b00, 2'b10, 5'b01000, 5'b00000, 5'b01000), "aw_first3");
        run_vec(mk(0, 5'b00000, 5'b00011, 5'b11010, 2'b01, 2'b10, 5'b00010, 5'b00000, 5'b00010), "aw_first4");
        run_vec(mk(0, 5'b00000, 5'b00000, 5'b00000, 2'b00, 2'b00, 5'b00000, 5'b00000, 5'b00000), "aw_first5");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
